// File: rtl/uart_pkg.sv
// Shared UART definitions: frame state type, data width and bit-timing helper.
// Defining UART_TX_PARITY_EN adds the even-parity PARITY state.
package uart_pkg;

  localparam int DATA_BITS = 8;
  localparam int IDX_W     = $clog2(DATA_BITS);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } uart_state_e;
`else
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } uart_state_e;
`endif

  // Clocks per serial bit; integer division, so the rate error is truncated.
  function automatic int bitCycles(input int clockRate, input int baudRate);
    return clockRate / baudRate;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Single-clock show-ahead FIFO with async reset; a push while full is
// honoured only when a pop happens in the same cycle.
module uart_tx_fifo #(
  parameter int DEPTH = 32,
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wrPtr_q, wrPtr_d;
  logic [AW-1:0]    rdPtr_q, rdPtr_d;
  logic [AW:0]      count_q, count_d;
  logic             doPush;
  logic             doPop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign rdata_o = mem[rdPtr_q];

  assign doPush = push_i && (!full_o || pop_i);
  assign doPop  = pop_i && !empty_o;

  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    if (doPush) wrPtr_d = wrPtr_q + AW'(1);
    if (doPop)  rdPtr_d = rdPtr_q + AW'(1);
    case ({doPush, doPop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (doPush) mem[wrPtr_q] <= wdata_i;
  end

endmodule

// File: rtl/uart_tx.sv
// Buffered 8-bit UART transmitter (8N1, or 8E1 when UART_TX_PARITY_EN is
// defined) with a held-request write handshake in front of the FIFO.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLOCK_RATE = 50000000,
  parameter int BAUD_RATE  = 9600,
  parameter int FIFO_DEPTH = 32
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_enable,
  input  logic [31:0] i_wdata,
  output logic        o_ready,
  output logic        o_waiting,
  output logic        o_busy,
  output logic        UART_TX
);

  localparam int BIT_CYCLES = bitCycles(CLOCK_RATE, BAUD_RATE);
  localparam int CNT_W      = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(BIT_CYCLES - 1);

  uart_state_e            state_q, state_d;
  logic [CNT_W-1:0]       baud_q, baud_d;
  logic [IDX_W-1:0]       bitIdx_q, bitIdx_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic                   tx_q, tx_d;
  logic                   ready_q, ready_d;
  logic                   waiting_q, waiting_d;

  logic                   push;
  logic                   pop;
  logic                   fifoFull;
  logic                   fifoEmpty;
  logic [DATA_BITS-1:0]   fifoRdata;
  logic                   baudDone;
  logic [23:0]            unusedWdata;

  assign unusedWdata = i_wdata[31:8];

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_BITS)
  ) u_fifo (
    .clk_i   (i_clock),
    .rst_i   (i_reset),
    .push_i  (push),
    .wdata_i (i_wdata[DATA_BITS-1:0]),
    .pop_i   (pop),
    .rdata_o (fifoRdata),
    .full_o  (fifoFull),
    .empty_o (fifoEmpty)
  );

  // ready_q doubles as "already accepted" so a held request pushes only once.
  assign push      = i_enable && !ready_q && (!fifoFull || pop);
  assign ready_d   = i_enable && (ready_q || push);
  assign waiting_d = i_enable && !ready_q && !push;

  assign baudDone = (baud_q == '0);

  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    bitIdx_d = bitIdx_q;
    shift_d  = shift_q;
    pop      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifoEmpty) begin
          pop     = 1'b1;
          shift_d = fifoRdata;
          state_d = ST_START;
          baud_d  = RELOAD;
        end
      end
      ST_START: begin
        baud_d = baud_q - CNT_W'(1);
        if (baudDone) begin
          state_d  = ST_DATA;
          bitIdx_d = '0;
          baud_d   = RELOAD;
        end
      end
      ST_DATA: begin
        baud_d = baud_q - CNT_W'(1);
        if (baudDone) begin
          baud_d = RELOAD;
          if (bitIdx_q == IDX_W'(DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end else begin
            bitIdx_d = bitIdx_q + IDX_W'(1);
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        baud_d = baud_q - CNT_W'(1);
        if (baudDone) begin
          state_d = ST_STOP;
          baud_d  = RELOAD;
        end
      end
`endif
      ST_STOP: begin
        baud_d = baud_q - CNT_W'(1);
        if (baudDone) begin
          baud_d = RELOAD;
          // Chain straight into the next frame so back-to-back bytes leave no idle gap.
          if (!fifoEmpty) begin
            pop     = 1'b1;
            shift_d = fifoRdata;
            state_d = ST_START;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    tx_d = 1'b1;
    case (state_d)
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = shift_d[bitIdx_d];
`ifdef UART_TX_PARITY_EN
      ST_PARITY: tx_d = ^shift_d;
`endif
      default:   tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q   <= ST_IDLE;
      baud_q    <= '0;
      bitIdx_q  <= '0;
      shift_q   <= '0;
      tx_q      <= 1'b1;
      ready_q   <= 1'b0;
      waiting_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      bitIdx_q  <= bitIdx_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
      ready_q   <= ready_d;
      waiting_q <= waiting_d;
    end
  end

  assign UART_TX   = tx_q;
  assign o_ready   = ready_q;
  assign o_waiting = waiting_q;
  assign o_busy    = (state_q != ST_IDLE) || !fifoEmpty;

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL have parameter CLOCK_RATE, default 50000000, meaning system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 9600, meaning serial bit rate in bit/s.
REQ-003 SHALL have parameter FIFO_DEPTH, default 32, meaning transmit FIFO entries; power of two, minimum 2.
REQ-004 SHALL have port i_clock  input  1  sole clock; all logic on rising edge.
REQ-005 SHALL have port i_reset  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port i_enable  input  1  bus write request, held high until o_ready is seen.
REQ-007 SHALL have port i_wdata  input  32  write data; only bits [7:0] used.
REQ-008 SHALL have port o_ready  output  1  write accepted; held while i_enable stays high.
REQ-009 SHALL have port o_waiting  output  1  request stalled because FIFO full.
REQ-010 SHALL have port o_busy  output  1  FIFO non-empty or frame in progress.
REQ-011 SHALL have port UART_TX  output  1  serial line, idle high.

Function
REQ-012 SHALL derive BIT_CYCLES = CLOCK_RATE / BAUD_RATE (integer division); every serial bit SHALL last exactly BIT_CYCLES clocks.
REQ-013 Write handshake: i_enable high and FIFO not full -> push i_wdata[7:0] that cycle, o_ready=1 next cycle, o_waiting=0; exactly one push per i_enable assertion.
REQ-014 i_enable high and FIFO full -> no push, o_waiting=1, retry every cycle until space, then REQ-013 applies.
REQ-015 i_enable low -> o_ready=0, o_waiting=0 next cycle; handshake re-arms.
REQ-016 Transmit FSM states: IDLE, START, DATA, STOP [, PARITY when enabled].
REQ-017 IDLE: UART_TX=1; FIFO non-empty -> pop head into shift register, go START; start bit appears on UART_TX at most 2 clocks after a push into an empty FIFO.
REQ-018 START: UART_TX=0 for BIT_CYCLES, then DATA with bit index 0.
REQ-019 DATA: drive shift register bits LSB first, 8 bits, BIT_CYCLES each; after bit 7 go STOP (or PARITY).
REQ-020 STOP: UART_TX=1 for BIT_CYCLES; then IDLE; if FIFO non-empty, next START begins the very next clock (no extra idle gap).
REQ-021 Baud counter SHALL reload to BIT_CYCLES-1 on every state entry and count down; no free-running divider.
REQ-022 Simultaneous push and pop in one cycle SHALL both take effect; occupancy unchanged; no data loss at full boundary.
REQ-023 FIFO read/write pointers SHALL wrap modulo FIFO_DEPTH; occupancy counter width clog2(FIFO_DEPTH)+1.
REQ-024 o_busy SHALL be 1 whenever FSM not IDLE or FIFO non-empty.
REQ-025 UART_TX SHALL be driven from a register (glitch-free).

Reset
REQ-026 On i_reset high, immediately: UART_TX=1, o_ready=0, o_waiting=0, o_busy=0, FSM=IDLE, FIFO empty, baud counter cleared.
REQ-027 Reset mid-frame SHALL abort the frame; line returns high without completing the byte; queued bytes discarded.
REQ-028 First transmission after reset release SHALL follow REQ-017 timing.

Configuration
REQ-029 Macro UART_TX_PARITY_EN defined: PARITY state after DATA drives even parity (XOR of 8 data bits) for BIT_CYCLES; frame = 11 bits.
REQ-030 Macro undefined: no PARITY state or logic; DATA goes directly to STOP; frame = 10 bits (8N1).

Structure
REQ-031 Package uart_pkg SHALL hold the FSM state typedef, DATA_BITS=8 constant, and the BIT_CYCLES derivation function, shared with the receiver.
REQ-032 FIFO SHALL be a separate sub-module uart_tx_fifo (synchronous, single clock, async reset, push/pop/full/empty/rdata).

Verification (CLOCK_RATE=1000000, BAUD_RATE=100000 -> BIT_CYCLES=10)
REQ-033 Write 0x55 once -> o_ready 1 clock after accept; UART_TX low 10 clocks, then 1,0,1,0,1,0,1,0 each 10 clocks, high 10 clocks; o_busy falls after stop.
REQ-034 Burst-write 0x00,0xFF,0xA5 back-to-back -> three contiguous 100-clock frames, no idle gap, bytes in order.
REQ-035 Fill 32 bytes while line sends, then write 33rd -> o_waiting=1 until first pop, then accepted; all 33 bytes transmitted in order.
REQ-036 Assert i_reset during bit 3 of 0x0F -> UART_TX=1 same cycle, o_busy=0, no further edges until a new write.
REQ-037 With UART_TX_PARITY_EN, write 0x07 -> parity bit 1 after data, frame 110 clocks; write 0x03 -> parity bit 0.
REQ-038 Hold i_enable high 50 clocks for one write -> exactly one byte queued, o_ready stays 1 until i_enable drops.
